// File: rtl/ahbmtx_l1_in_stg.sv
// Per-master AHB bus matrix input stage: passes the live address phase, or holds it while the output port stalls.
// Latency: zero-cycle pass-through, or one cycle more through the holding register. Backpressure: HREADYOUTS low while a phase is held.
// Optional hold-length counter is built when AHBMTX_INSTG_HOLD_CNT_EN is defined.
module ahbmtx_l1_in_stg #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    output logic              sel_op,
    output logic [ADDR_W-1:0] addr_op,
    output logic [1:0]        trans_op,
    output logic              write_op,
    output logic [2:0]        size_op,
    output logic [2:0]        burst_op,
    output logic [3:0]        prot_op,
    output logic              lock_op,
    input  logic              addr_accept,
    input  logic              readyout_dec,
    input  logic              resp_dec,
    output logic [7:0]        hold_cycles
);

    logic              pend_tran_q, pend_tran_d;
    logic              data_phase_q, data_phase_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        trans_q, trans_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic [2:0]        burst_q, burst_d;
    logic [3:0]        prot_q, prot_d;
    logic              lock_q, lock_d;

    logic live_req;
    logic capture;
    logic release_hold;

    // IDLE/BUSY never form a request, so they are never captured and always pass live.
    assign live_req     = HSELS & HTRANSS[1] & HREADYS;
    assign capture      = ~pend_tran_q & live_req & ~addr_accept;
    assign release_hold = pend_tran_q & addr_accept;

    always_comb begin
        pend_tran_d  = pend_tran_q;
        data_phase_d = data_phase_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        trans_d      = trans_q;
        write_d      = write_q;
        size_d       = size_q;
        burst_d      = burst_q;
        prot_d       = prot_q;
        lock_d       = lock_q;

        if (capture) begin
            pend_tran_d = 1'b1;
            sel_d       = HSELS;
            addr_d      = HADDRS;
            trans_d     = HTRANSS;
            write_d     = HWRITES;
            size_d      = HSIZES;
            burst_d     = HBURSTS;
            prot_d      = HPROTS;
            lock_d      = HMASTLOCKS;
        end else if (release_hold) begin
            pend_tran_d = 1'b0;
        end

        if (addr_accept) begin
            data_phase_d = 1'b1;
        end else if (readyout_dec) begin
            data_phase_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_tran_q  <= 1'b0;
            data_phase_q <= 1'b0;
            sel_q        <= 1'b0;
            addr_q       <= '0;
            trans_q      <= 2'b00;
            write_q      <= 1'b0;
            size_q       <= 3'b000;
            burst_q      <= 3'b000;
            prot_q       <= 4'h0;
            lock_q       <= 1'b0;
        end else begin
            pend_tran_q  <= pend_tran_d;
            data_phase_q <= data_phase_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            trans_q      <= trans_d;
            write_q      <= write_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            prot_q       <= prot_d;
            lock_q       <= lock_d;
        end
    end

    // Live path masks the transfer type while the bus is stalled so the matrix never sees a stale request.
    always_comb begin
        if (pend_tran_q) begin
            sel_op   = sel_q;
            addr_op  = addr_q;
            trans_op = trans_q;
            write_op = write_q;
            size_op  = size_q;
            burst_op = burst_q;
            prot_op  = prot_q;
            lock_op  = lock_q;
        end else begin
            sel_op   = HSELS & HREADYS;
            addr_op  = HADDRS;
            trans_op = HREADYS ? HTRANSS : 2'b00;
            write_op = HWRITES;
            size_op  = HSIZES;
            burst_op = HBURSTS;
            prot_op  = HPROTS;
            lock_op  = HMASTLOCKS;
        end
    end

    assign HREADYOUTS = data_phase_q ? readyout_dec : ~pend_tran_q;
    assign HRESPS     = data_phase_q ? resp_dec : 1'b0;

`ifdef AHBMTX_INSTG_HOLD_CNT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (capture) begin
            hold_cnt_d = 8'd1;
        end else if (pend_tran_q && !addr_accept && hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_cnt_q <= 8'h00;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign hold_cycles = hold_cnt_q;
`else
    assign hold_cycles = 8'h00;
`endif

endmodule

// File: tb/tb_ahbmtx_l1_in_stg.sv
// Directed bench for ahbmtx_l1_in_stg: reset, direct accept, held transfer, wait states, ERROR response, reset mid-hold.
module tb_ahbmtx_l1_in_stg;

    logic        HCLK;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic        lock_op;
    logic        addr_accept;
    logic        readyout_dec;
    logic        resp_dec;
    logic [7:0]  hold_cycles;

    int checks;
    int errors;

`ifdef AHBMTX_INSTG_HOLD_CNT_EN
    localparam logic [7:0] EXP_HOLD = 8'd4;
`else
    localparam logic [7:0] EXP_HOLD = 8'd0;
`endif

    ahbmtx_l1_in_stg #(.ADDR_W(32)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .sel_op       (sel_op),
        .addr_op      (addr_op),
        .trans_op     (trans_op),
        .write_op     (write_op),
        .size_op      (size_op),
        .burst_op     (burst_op),
        .prot_op      (prot_op),
        .lock_op      (lock_op),
        .addr_accept  (addr_accept),
        .readyout_dec (readyout_dec),
        .resp_dec     (resp_dec),
        .hold_cycles  (hold_cycles)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        HSELS        = 1'b0;
        HADDRS       = 32'h0;
        HTRANSS      = 2'b00;
        HWRITES      = 1'b0;
        HSIZES       = 3'd0;
        HBURSTS      = 3'd0;
        HPROTS       = 4'h0;
        HMASTLOCKS   = 1'b0;
        HREADYS      = 1'b1;
        addr_accept  = 1'b0;
        readyout_dec = 1'b1;
        resp_dec     = 1'b0;
    endtask

    task automatic drive_nonseq(input logic [31:0] a, input logic w, input logic [2:0] sz);
        HSELS   = 1'b1;
        HADDRS  = a;
        HTRANSS = 2'b10;
        HWRITES = w;
        HSIZES  = sz;
        HREADYS = 1'b1;
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        HRESETn = 1'b0;
        drive_idle();
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Reset state
        @(negedge HCLK);
        check_eq("rst_readyout", HREADYOUTS, 1);
        check_eq("rst_resp", HRESPS, 0);
        check_eq("rst_trans", trans_op, 0);
        check_eq("rst_hold", hold_cycles, 0);
        next_cycle();

        // Direct accept
        drive_nonseq(32'h2000_0000, 1'b0, 3'd2);
        addr_accept = 1'b1;
        @(negedge HCLK);
        check_eq("dir_addr", addr_op, 32'h2000_0000);
        check_eq("dir_trans", trans_op, 2'b10);
        check_eq("dir_sel", sel_op, 1);
        check_eq("dir_rdy_addr", HREADYOUTS, 1);
        next_cycle();
        drive_idle();
        HSELS  = 1'b1;
        HADDRS = 32'h0000_1234;
        @(negedge HCLK);
        check_eq("dir_rdy_data", HREADYOUTS, 1);
        check_eq("dir_no_capture", addr_op, 32'h0000_1234);
        next_cycle();

        // Held transfer: capture cycle, three stalled cycles, then accept
        drive_nonseq(32'h4000_0010, 1'b1, 3'd2);
        HBURSTS    = 3'b001;
        HPROTS     = 4'hA;
        HMASTLOCKS = 1'b1;
        @(negedge HCLK);
        check_eq("hold_cap_rdy", HREADYOUTS, 1);
        next_cycle();
        HADDRS     = 32'hDEAD_0000;
        HWRITES    = 1'b0;
        HSIZES     = 3'd0;
        HBURSTS    = 3'b000;
        HPROTS     = 4'h0;
        HMASTLOCKS = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_accept = (i == 3);
            @(negedge HCLK);
            check_eq($sformatf("hold_addr%0d", i), addr_op, 32'h4000_0010);
            check_eq($sformatf("hold_write%0d", i), write_op, 1);
            check_eq($sformatf("hold_rdy%0d", i), HREADYOUTS, 0);
            if (i == 3) begin
                check_eq("hold_trans", trans_op, 2'b10);
                check_eq("hold_size", size_op, 3'd2);
                check_eq("hold_burst", burst_op, 3'b001);
                check_eq("hold_prot", prot_op, 4'hA);
                check_eq("hold_lock", lock_op, 1);
            end
            next_cycle();
        end
        addr_accept = 1'b0;
        HTRANSS     = 2'b00;
        @(negedge HCLK);
        check_eq("hold_data_rdy", HREADYOUTS, 1);
        check_eq("hold_released", addr_op, 32'hDEAD_0000);
        check_eq("hold_cycles", hold_cycles, {24'h0, EXP_HOLD});
        next_cycle();

        // Slave wait states
        drive_nonseq(32'h0000_0100, 1'b0, 3'd2);
        addr_accept = 1'b1;
        @(negedge HCLK);
        check_eq("ws_addr_rdy", HREADYOUTS, 1);
        next_cycle();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            readyout_dec = (i == 2);
            @(negedge HCLK);
            check_eq($sformatf("ws_rdy%0d", i), HREADYOUTS, (i == 2) ? 1 : 0);
            next_cycle();
        end
        readyout_dec = 1'b0;
        @(negedge HCLK);
        check_eq("ws_dp_clear", HREADYOUTS, 1);
        next_cycle();

        // ERROR response; NONSEQ driven while HREADY low must not be captured
        drive_idle();
        drive_nonseq(32'h0000_0200, 1'b1, 3'd2);
        addr_accept = 1'b1;
        next_cycle();
        drive_idle();
        HSELS        = 1'b1;
        HTRANSS      = 2'b10;
        HREADYS      = 1'b0;
        resp_dec     = 1'b1;
        readyout_dec = 1'b0;
        @(negedge HCLK);
        check_eq("err1_resp", HRESPS, 1);
        check_eq("err1_rdy", HREADYOUTS, 0);
        check_eq("err1_trans_masked", trans_op, 0);
        check_eq("err1_sel_masked", sel_op, 0);
        next_cycle();
        HTRANSS      = 2'b00;
        HREADYS      = 1'b1;
        readyout_dec = 1'b1;
        @(negedge HCLK);
        check_eq("err2_resp", HRESPS, 1);
        check_eq("err2_rdy", HREADYOUTS, 1);
        next_cycle();
        resp_dec     = 1'b0;
        readyout_dec = 1'b0;
        @(negedge HCLK);
        check_eq("err_done_resp", HRESPS, 0);
        check_eq("err_done_rdy", HREADYOUTS, 1);
        next_cycle();

        // Reset mid-hold
        drive_idle();
        drive_nonseq(32'h5000_0000, 1'b1, 3'd1);
        next_cycle();
        HADDRS = 32'h0;
        @(negedge HCLK);
        check_eq("rh_held_rdy", HREADYOUTS, 0);
        check_eq("rh_held_addr", addr_op, 32'h5000_0000);
        #1;
        HSELS   = 1'b0;
        HTRANSS = 2'b00;
        HRESETn = 1'b0;
        #1;
        check_eq("rh_rdy_now", HREADYOUTS, 1);
        check_eq("rh_trans_now", trans_op, 0);
        check_eq("rh_hold_now", hold_cycles, 0);
        #1;
        HRESETn = 1'b1;
        next_cycle();
        @(negedge HCLK);
        check_eq("rh_after_rdy", HREADYOUTS, 1);
        check_eq("rh_after_trans", trans_op, 0);
        check_eq("rh_after_addr", addr_op, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
